// File: rtl/map_pixel_fetch_pkg.sv
// map_pixel_fetch_pkg: shared display constants, coordinate width and RGB444 colour type
package map_pixel_fetch_pkg;
  localparam int SCR_W   = 320;
  localparam int SCR_H   = 240;
  localparam int SCR_CX  = 160;
  localparam int SCR_CY  = 120;
  localparam int COORD_W = 9;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [11:0] rgb444_t;
  localparam rgb444_t RGB_BLACK = 12'h000;
  localparam rgb444_t RGB_RED   = 12'hF00;
  localparam rgb444_t RGB_WHITE = 12'hFFF;
endpackage

// File: rtl/map_marker_blink.sv
// map_marker_blink: counts vsync falling edges and flips blink_on every BLINK_FRAMES frames
module map_marker_blink
  import map_pixel_fetch_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic blink_on
);
  localparam int CNT_W = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic             vsync_q;
  logic [CNT_W-1:0] cnt;
  logic             frame_start;
  logic             wrap;
  assign frame_start = vsync_q && !vsync;
  assign wrap        = cnt == CNT_W'(BLINK_FRAMES - 1);
  // previous vsync level; syncs idle high so reset to 1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vsync_q <= 1'b1;
    else vsync_q <= vsync;
  // each frame start advances the counter; its wrap flips the marker phase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt      <= '0;
      blink_on <= 1'b1;
    end else if (frame_start) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
      if (wrap) blink_on <= !blink_on;
    end
endmodule

// File: rtl/map_pixel_fetch.sv
// map_pixel_fetch: 3-clk map memory fetch with aligned syncs; marker overlay enabled by MAP_PIXEL_FETCH_MARKER_EN
module map_pixel_fetch
  import map_pixel_fetch_pkg::*;
#(
  parameter int      MAP_W        = 320,
  parameter int      MAP_H        = 240,
  parameter int      ADDR_W       = 17,
  parameter rgb444_t BG_COLOR     = 12'h000,
  parameter rgb444_t MARKER_COLOR = 12'hF00,
  parameter int      MARKER_R     = 3,
  parameter int      BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  coord_t            pixel_x,
  input  coord_t            pixel_y,
  input  coord_t            map_x,
  input  coord_t            map_y,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [11:0]       mem_rdata,
  output logic [11:0]       rgb_out,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out
);
  logic              in_map_c;
  logic [ADDR_W-1:0] addr_c;
  logic              in_map2;
  logic [2:0]        ctl1, ctl2;
  rgb444_t           rgb_c;
  assign in_map_c = de_in && int'(map_x) < MAP_W && int'(map_y) < MAP_H;
  assign addr_c   = ADDR_W'(map_y) * ADDR_W'(MAP_W) + ADDR_W'(map_x);
`ifdef MAP_PIXEL_FETCH_MARKER_EN
  logic marker_c, marker1, marker2, blink_on;
  assign marker_c = int'(pixel_x) - SCR_CX <= MARKER_R && SCR_CX - int'(pixel_x) <= MARKER_R &&
                    int'(pixel_y) - SCR_CY <= MARKER_R && SCR_CY - int'(pixel_y) <= MARKER_R;
  map_marker_blink #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk      (clk),
    .rst_n    (rst_n),
    .vsync    (vsync_in),
    .blink_on (blink_on)
  );
  // carry the marker hit alongside its pixel through S1 and S2
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {marker1, marker2} <= 2'b00;
    else {marker1, marker2} <= {marker_c, marker1};
  assign rgb_c = !ctl2[2] ? RGB_BLACK : (marker2 && blink_on) ? MARKER_COLOR : in_map2 ? mem_rdata : BG_COLOR;
`else
  logic unused_marker;
  assign unused_marker = ^{pixel_x, pixel_y, MARKER_COLOR, MARKER_R, BLINK_FRAMES};
  assign rgb_c = !ctl2[2] ? RGB_BLACK : in_map2 ? mem_rdata : BG_COLOR;
`endif
  // S1 issues the read, S2 waits for data, S3 registers the pixel with its delayed {de,hsync,vsync}
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      in_map2   <= 1'b0;
      ctl1      <= 3'b011;
      ctl2      <= 3'b011;
      rgb_out   <= RGB_BLACK;
      {de_out, hsync_out, vsync_out} <= 3'b011;
    end else begin
      mem_rd_en <= in_map_c;
      if (in_map_c) mem_addr <= addr_c;
      in_map2 <= mem_rd_en;
      ctl1    <= {de_in, hsync_in, vsync_in};
      ctl2    <= ctl1;
      rgb_out <= rgb_c;
      {de_out, hsync_out, vsync_out} <= ctl2;
    end
endmodule

// File: tb/tb_map_pixel_fetch.sv
// tb_map_pixel_fetch: directed scenarios plus randomized pixels checked against a frame-count reference model
`timescale 1ns/1ps
module tb_map_pixel_fetch;
  localparam int MAP_W = 320, MAP_H = 240, ADDR_W = 17, BF = 30;
  localparam logic [11:0] BG = 12'h05A, MK = 12'hF00;
  typedef struct {
    bit de, hs, vs;
    int px, py, mx, my, falls;
  } vec_t;
  logic clk = 0, rst_n = 0, de_in = 0, hsync_in = 1, vsync_in = 1;
  logic [8:0] pixel_x = 0, pixel_y = 0, map_x = 0, map_y = 0;
  logic mem_rd_en, de_out, hsync_out, vsync_out;
  logic [ADDR_W-1:0] mem_addr;
  logic [11:0] mem_rdata = 0, rgb_out;
  int n_cmp = 0, n_err = 0;
  vec_t hist[$];
  always #5 clk = ~clk;
  map_pixel_fetch #(.BG_COLOR(BG)) dut (
    .clk(clk), .rst_n(rst_n), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .map_x(map_x), .map_y(map_y),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rgb_out(rgb_out), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );
  function automatic logic [11:0] mem_fn(int a);
    return a == 645 ? 12'hABC : 12'((a * 37 + 11) ^ (a >> 5));
  endfunction
  // memory answers one cycle after a read; garbage otherwise so stale sampling shows up
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem_fn(int'(mem_addr)) : 12'($urandom);
  // expected pixel for vector k; blink phase follows frame starts seen up to vector k+1
  function automatic logic [11:0] model_rgb(int k);
    vec_t v;
    bit hit, blink;
    v = hist[k];
    if (!v.de) return 12'h000;
`ifdef MAP_PIXEL_FETCH_MARKER_EN
    blink = ((hist[k+1].falls / BF) % 2) == 0;
    hit = v.px >= 157 && v.px <= 163 && v.py >= 117 && v.py <= 123;
    if (hit && blink) return MK;
`endif
    if (v.mx < MAP_W && v.my < MAP_H) return mem_fn(v.my * MAP_W + v.mx);
    return BG;
  endfunction
  task automatic drive(bit de, bit hs, bit vs, int px, int py, int mx, int my);
    vec_t v;
    bit pv;
    @(negedge clk);
    pv = hist.size() > 0 ? hist[hist.size()-1].vs : 1'b1;
    v.de = de; v.hs = hs; v.vs = vs; v.px = px; v.py = py; v.mx = mx; v.my = my;
    v.falls = (hist.size() > 0 ? hist[hist.size()-1].falls : 0) + ((pv && !vs) ? 1 : 0);
    hist.push_back(v);
    de_in = de; hsync_in = hs; vsync_in = vs;
    pixel_x = 9'(px); pixel_y = 9'(py); map_x = 9'(mx); map_y = 9'(my);
  endtask
  task automatic send(bit de, bit hs, bit vs, int px, int py, int mx, int my);
    drive(de, hs, vs, px, py, mx, my);
    @(posedge clk); #1;
  endtask
  task automatic settle();
    drive(0, 1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst_n = 0; de_in = 0; hsync_in = 1; vsync_in = 1;
    pixel_x = 0; pixel_y = 0; map_x = 0; map_y = 0;
    hist.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({rgb_out, de_out, hsync_out, vsync_out} !== {12'h000, 3'b011}) begin
      n_err++; $display("FAIL reset_out: got rgb=%h de=%b hs=%b vs=%b want 000/0/1/1", rgb_out, de_out, hsync_out, vsync_out);
    end
    n_cmp++;
    if (mem_rd_en !== 1'b0 || mem_addr !== '0) begin
      n_err++; $display("FAIL reset_mem: got en=%b addr=%0d want 0/0", mem_rd_en, mem_addr);
    end
  endtask
  task automatic test_in_map();
    send(1, 1, 1, 0, 0, 5, 2);
    n_cmp++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 17'd645) begin
      n_err++; $display("FAIL in_map_addr: got en=%b addr=%0d want 1/645", mem_rd_en, mem_addr);
    end
    settle();
    n_cmp++;
    if (rgb_out !== 12'hABC || de_out !== 1'b1) begin
      n_err++; $display("FAIL in_map_rgb: got rgb=%h de=%b want abc/1", rgb_out, de_out);
    end
  endtask
  task automatic test_out_of_map();
    send(1, 1, 1, 0, 0, 400, 10);
    n_cmp++;
    if (mem_rd_en !== 1'b0 || mem_addr !== 17'd645) begin
      n_err++; $display("FAIL oom_mem: got en=%b addr=%0d want 0/645 held", mem_rd_en, mem_addr);
    end
    settle();
    n_cmp++;
    if (rgb_out !== BG || de_out !== 1'b1) begin
      n_err++; $display("FAIL oom_rgb: got rgb=%h de=%b want %h/1", rgb_out, de_out, BG);
    end
  endtask
  task automatic test_boundary();
    send(1, 1, 1, 0, 0, MAP_W - 1, MAP_H - 1);
    n_cmp++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 17'(MAP_W * MAP_H - 1)) begin
      n_err++; $display("FAIL corner_addr: got en=%b addr=%0d want 1/%0d", mem_rd_en, mem_addr, MAP_W * MAP_H - 1);
    end
    settle();
    n_cmp++;
    if (rgb_out !== mem_fn(MAP_W * MAP_H - 1)) begin
      n_err++; $display("FAIL corner_rgb: got %h want %h", rgb_out, mem_fn(MAP_W * MAP_H - 1));
    end
    send(1, 1, 1, 0, 0, MAP_W, 0);
    n_cmp++;
    if (mem_rd_en !== 1'b0) begin
      n_err++; $display("FAIL x_edge_en: got %b want 0", mem_rd_en);
    end
    settle();
    n_cmp++;
    if (rgb_out !== BG) begin
      n_err++; $display("FAIL x_edge_rgb: got %h want %h", rgb_out, BG);
    end
  endtask
  task automatic test_de_off();
    send(0, 0, 0, 0, 0, 5, 2);
    n_cmp++;
    if (mem_rd_en !== 1'b0) begin
      n_err++; $display("FAIL de_off_en: got %b want 0", mem_rd_en);
    end
    settle();
    n_cmp++;
    if ({rgb_out, de_out, hsync_out, vsync_out} !== {12'h000, 3'b000}) begin
      n_err++; $display("FAIL de_off_out: got rgb=%h de=%b hs=%b vs=%b want 000/0/0/0", rgb_out, de_out, hsync_out, vsync_out);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({hsync_out, vsync_out} !== 2'b11) begin
      n_err++; $display("FAIL sync_release: got hs=%b vs=%b want 1/1", hsync_out, vsync_out);
    end
  endtask
`ifdef MAP_PIXEL_FETCH_MARKER_EN
  task automatic test_marker();
    do_reset();
    send(1, 1, 1, 160, 120, 5, 2); settle();
    n_cmp++;
    if (rgb_out !== MK) begin n_err++; $display("FAIL marker_centre: got %h want %h", rgb_out, MK); end
    send(1, 1, 1, 163, 117, 5, 2); settle();
    n_cmp++;
    if (rgb_out !== MK) begin n_err++; $display("FAIL marker_corner: got %h want %h", rgb_out, MK); end
    send(1, 1, 1, 164, 120, 5, 2); settle();
    n_cmp++;
    if (rgb_out !== 12'hABC) begin n_err++; $display("FAIL marker_outside: got %h want abc", rgb_out); end
    for (int i = 0; i < BF; i++) begin drive(0, 1, 0, 0, 0, 0, 0); drive(0, 1, 1, 0, 0, 0, 0); end
    send(1, 1, 1, 160, 120, 7, 7); settle();
    n_cmp++;
    if (rgb_out !== mem_fn(7 * MAP_W + 7)) begin n_err++; $display("FAIL blink_off: got %h want %h", rgb_out, mem_fn(7 * MAP_W + 7)); end
    for (int i = 0; i < BF; i++) begin drive(0, 1, 0, 0, 0, 0, 0); drive(0, 1, 1, 0, 0, 0, 0); end
    send(1, 1, 1, 160, 120, 7, 7); settle();
    n_cmp++;
    if (rgb_out !== MK) begin n_err++; $display("FAIL blink_on_again: got %h want %h", rgb_out, MK); end
  endtask
`else
  task automatic test_no_marker();
    send(1, 1, 1, 160, 120, 9, 4); settle();
    n_cmp++;
    if (rgb_out !== mem_fn(4 * MAP_W + 9)) begin n_err++; $display("FAIL no_marker: got %h want %h", rgb_out, mem_fn(4 * MAP_W + 9)); end
  endtask
`endif
  task automatic test_midline_reset();
    do_reset();
    drive(1, 0, 0, 10, 10, 5, 2);
    drive(1, 0, 1, 11, 10, 6, 2);
    drive(1, 0, 1, 12, 10, 7, 2);
    @(posedge clk); #2;
    rst_n = 0; #1;
    n_cmp++;
    if ({rgb_out, de_out, hsync_out, vsync_out, mem_rd_en} !== {12'h000, 4'b0110}) begin
      n_err++; $display("FAIL midline_reset: got rgb=%h de=%b hs=%b vs=%b en=%b want 000/0/1/1/0", rgb_out, de_out, hsync_out, vsync_out, mem_rd_en);
    end
    do_reset();
    drive(1, 1, 1, 0, 0, 5, 2);
    @(posedge clk); #1;
    n_cmp++;
    if (de_out !== 1'b0) begin n_err++; $display("FAIL post_reset_de1: got %b want 0", de_out); end
    drive(0, 1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    n_cmp++;
    if (de_out !== 1'b0) begin n_err++; $display("FAIL post_reset_de2: got %b want 0", de_out); end
    drive(0, 1, 1, 0, 0, 0, 0);
    @(posedge clk); #1;
    n_cmp++;
    if (de_out !== 1'b1 || rgb_out !== 12'hABC) begin n_err++; $display("FAIL post_reset_de3: got de=%b rgb=%h want 1/abc", de_out, rgb_out); end
  endtask
  task automatic test_random();
    int px, py, mx, my, last_addr;
    bit de, hs, vs, inm;
    vec_t o;
    do_reset();
    last_addr = 0;
    for (int m = 0; m < 800; m++) begin
      de = $urandom_range(7) != 0;
      hs = $urandom_range(3) != 0;
      vs = $urandom_range(3) != 0;
      px = $urandom_range(1) ? 155 + int'($urandom_range(10)) : int'($urandom_range(319));
      py = $urandom_range(1) ? 115 + int'($urandom_range(10)) : int'($urandom_range(239));
      mx = $urandom_range(3) == 0 ? int'($urandom_range(511)) : int'($urandom_range(319));
      my = $urandom_range(3) == 0 ? int'($urandom_range(511)) : int'($urandom_range(239));
      send(de, hs, vs, px, py, mx, my);
      inm = de && mx < MAP_W && my < MAP_H;
      if (inm) last_addr = my * MAP_W + mx;
      n_cmp++;
      if (mem_rd_en !== inm || mem_addr !== 17'(last_addr)) begin
        n_err++; $display("FAIL rand_mem[%0d]: got en=%b addr=%0d want %b/%0d", m, mem_rd_en, mem_addr, inm, last_addr);
      end
      if (m >= 2) begin
        o = hist[m-2];
        n_cmp++;
        if (rgb_out !== model_rgb(m - 2) || {de_out, hsync_out, vsync_out} !== {o.de, o.hs, o.vs}) begin
          n_err++; $display("FAIL rand_out[%0d]: got rgb=%h ctl=%b%b%b want rgb=%h ctl=%b%b%b", m - 2, rgb_out, de_out, hsync_out, vsync_out, model_rgb(m - 2), o.de, o.hs, o.vs);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_in_map();
    test_out_of_map();
    test_boundary();
    test_de_off();
`ifdef MAP_PIXEL_FETCH_MARKER_EN
    test_marker();
`else
    test_no_marker();
`endif
    test_midline_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
